// File: rtl/eeg_dwt_rle_codec.sv
// Single-level Haar DWT, threshold and dual-band (approximation/detail) run-length encoder for one EEG channel.
// Define EEG_SOFT_THRESHOLD_EN for soft thresholding; the default build uses a hard threshold.
module eeg_dwt_rle_codec #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW:0]          thr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic                 flush,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic signed [DW:0]   a_data,
    output logic [CW-1:0]        a_count,
    output logic                 d_valid,
    input  logic                 d_ready,
    output logic signed [DW:0]   d_data,
    output logic [CW-1:0]        d_count,
    output logic                 flush_done
);
    localparam logic [CW-1:0] MAX_RUN = '1;

    typedef enum logic [2:0] {RUN, PAD, DRAIN, EMIT, DONE} state_t;

    state_t               state;
    logic                 phase;
    logic signed [DW-1:0] x0;
    logic signed [DW:0]   coef [2];
    logic                 coef_valid;

    // Index 0 is the approximation band, index 1 the detail band.
    logic [1:0]           run_act;
    logic signed [DW:0]   run_val [2];
    logic [CW-1:0]        run_cnt [2];
    logic [1:0]           o_valid;
    logic signed [DW:0]   o_data [2];
    logic [CW-1:0]        o_count [2];

    logic [1:0]           o_ready;
    logic signed [DW:0]   v [2];
    logic [1:0]           need_emit;
    logic [1:0]           can_take;
    logic                 consumed;
    logic                 accept;

    // Magnitude uses DW+2 bits so the most negative coefficient maps to +2^DW.
    function automatic logic signed [DW:0] thresh(input logic signed [DW:0] c, input logic [DW:0] t);
        logic [DW+1:0] mag;
`ifdef EEG_SOFT_THRESHOLD_EN
        logic [DW:0]   res;
`endif
        mag = c[DW] ? -{c[DW], c} : {c[DW], c};
        if (mag < {1'b0, t}) return '0;
`ifdef EEG_SOFT_THRESHOLD_EN
        res = mag[DW:0] - t;
        return c[DW] ? -res : res;
`else
        return c;
`endif
    endfunction

    always_comb begin
        o_ready = {d_ready, a_ready};
        for (int b = 0; b < 2; b++) begin
            v[b]         = thresh(coef[b], thr);
            need_emit[b] = run_act[b] && ((v[b] != run_val[b]) || (run_cnt[b] == MAX_RUN));
            can_take[b]  = !need_emit[b] || !o_valid[b] || o_ready[b];
        end
        // Both bands advance together so their runs stay aligned to the same coefficient pairs.
        consumed = coef_valid && (&can_take);
        in_ready = (state == RUN) && !flush && (!coef_valid || consumed);
        accept   = in_valid && in_ready;
    end

    assign a_valid = o_valid[0];
    assign a_data  = o_data[0];
    assign a_count = o_count[0];
    assign d_valid = o_valid[1];
    assign d_data  = o_data[1];
    assign d_count = o_count[1];

    // NOTE: run and output registers are reset too, so a mid-epoch reset cannot leak a stale run into the next epoch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            phase      <= 1'b0;
            x0         <= '0;
            coef_valid <= 1'b0;
            flush_done <= 1'b0;
            run_act    <= '0;
            o_valid    <= '0;
            for (int b = 0; b < 2; b++) begin
                coef[b]    <= '0;
                run_val[b] <= '0;
                run_cnt[b] <= '0;
                o_data[b]  <= '0;
                o_count[b] <= '0;
            end
        end else begin
            flush_done <= 1'b0;
            if (consumed) coef_valid <= 1'b0;

            for (int b = 0; b < 2; b++) begin
                if (o_valid[b] && o_ready[b]) o_valid[b] <= 1'b0;
                if (consumed) begin
                    if (need_emit[b]) begin
                        o_valid[b] <= 1'b1;
                        o_data[b]  <= run_val[b];
                        o_count[b] <= run_cnt[b];
                    end
                    run_act[b] <= 1'b1;
                    run_val[b] <= v[b];
                    run_cnt[b] <= (run_act[b] && !need_emit[b]) ? run_cnt[b] + 1'b1 : CW'(1);
                end else if (state == EMIT && run_act[b] && (!o_valid[b] || o_ready[b])) begin
                    o_valid[b] <= 1'b1;
                    o_data[b]  <= run_val[b];
                    o_count[b] <= run_cnt[b];
                    run_act[b] <= 1'b0;
                end
            end

            case (state)
                RUN: begin
                    if (flush) begin
                        state <= PAD;
                    end else if (accept) begin
                        if (!phase) begin
                            x0    <= in_data;
                            phase <= 1'b1;
                        end else begin
                            coef[0]    <= {x0[DW-1], x0} + {in_data[DW-1], in_data};
                            coef[1]    <= {x0[DW-1], x0} - {in_data[DW-1], in_data};
                            coef_valid <= 1'b1;
                            phase      <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    // An odd trailing sample is paired with zero; wait if the previous pair is still held.
                    if (!phase) begin
                        state <= DRAIN;
                    end else if (!coef_valid || consumed) begin
                        coef[0]    <= {x0[DW-1], x0};
                        coef[1]    <= {x0[DW-1], x0};
                        coef_valid <= 1'b1;
                        phase      <= 1'b0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: if (!coef_valid) state <= EMIT;
                EMIT:  if (run_act == 2'b00 && o_valid == 2'b00) state <= DONE;
                DONE: begin
                    flush_done <= 1'b1;
                    phase      <= 1'b0;
                    state      <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
